// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and small arithmetic helpers for the
// sprite line renderer.
//   SPRITE_W    : sprite width/height in pixels (32)
//   IDX_W       : bits needed to index one sprite row/column (5)
//   COORD_W     : screen coordinate width (10)
//   PIX_W       : RGB333 pixel width (9)
//   TRANSPARENT : sprite colour treated as see-through
//   BG_COLOUR   : colour of active pixels not covered by any sprite
package sprite_pkg;

    localparam int SPRITE_W = 32;
    localparam int IDX_W    = 5;
    localparam int COORD_W  = 10;
    localparam int PIX_W    = 9;

    localparam logic [PIX_W-1:0] TRANSPARENT = 9'b111000111;
    localparam logic [PIX_W-1:0] BG_COLOUR   = 9'b000010000;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPRITE_W - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_FROG = 2'd1,
        FETCH_CAR  = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    // Unsigned difference a - b in COORD_W+1 bits; bit COORD_W acts as sign.
    function automatic logic [COORD_W:0] coord_offset(input logic [COORD_W-1:0] a,
                                                      input logic [COORD_W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // True when 0 <= d < SPRITE_W (d is a signed coord_offset result).
    function automatic logic in_sprite(input logic [COORD_W:0] d);
        return (d[COORD_W:IDX_W] == '0);
    endfunction

endpackage

// File: rtl/sprite_line_buffer.sv
// One sprite row held in registers: SPRITE_W entries of PIX_W bits.
//   i_Clk   : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write data
//   i_raddr : read index (asynchronous read)
//   o_rdata : read data
// Contents are not reset; they are only meaningful after a fetch.
module sprite_line_buffer
    import sprite_pkg::*;
(
    input  logic             i_Clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] mem_q [SPRITE_W];
    logic [PIX_W-1:0] mem_d [SPRITE_W];

    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            mem_d[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge i_Clk) begin
        mem_q <= mem_d;
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sprite_line_renderer.sv
// Fetches the frog and car sprite rows needed for the next scan line during
// horizontal blanking, then composites frog over car over background during
// active video, one registered RGB333 pixel per clock.
//   i_Clk, i_Rst          : clock, synchronous active-high reset
//   i_line_start          : hblank start pulse; latches row/positions, starts fetch
//   i_next_row            : screen row shown after this blank
//   i_frog_x/y, i_car_x/y : sprite top-left positions
//   i_active, i_col       : display enable and current column
//   o_read_en/addr        : sprite memory read port (data back one cycle later)
//   o_mem_select          : 0 = frog bank, 1 = car bank
//   i_read_data           : sprite memory read data
//   o_pixel               : composited pixel (one cycle after i_col)
//   o_busy                : fetch in progress
//
// state      | meaning
// IDLE       | no fetch; line buffers hold the current line
// FETCH_FROG | 32 reads of the frog row from the frog bank
// FETCH_CAR  | 32 reads of the car row from the car bank
// DRAIN      | last read's data returns and is written
module sprite_line_renderer
    import sprite_pkg::*;
(
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_line_start,
    input  logic [COORD_W-1:0] i_next_row,
    input  logic [COORD_W-1:0] i_frog_x,
    input  logic [COORD_W-1:0] i_frog_y,
    input  logic [COORD_W-1:0] i_car_x,
    input  logic [COORD_W-1:0] i_car_y,
    input  logic               i_active,
    input  logic [COORD_W-1:0] i_col,
    output logic               o_read_en,
    output logic [COORD_W-1:0] o_read_addr,
    output logic               o_mem_select,
    input  logic [PIX_W-1:0]   i_read_data,
    output logic [PIX_W-1:0]   o_pixel,
    output logic               o_busy
);

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [IDX_W-1:0]   frog_dy_q,  frog_dy_d;
    logic [IDX_W-1:0]   car_dy_q,   car_dy_d;
    logic               frog_hit_q, frog_hit_d;
    logic               car_hit_q,  car_hit_d;
    logic [COORD_W-1:0] frog_x_q,   frog_x_d;
    logic [COORD_W-1:0] car_x_q,    car_x_d;
    logic               ret_valid_q, ret_valid_d;
    logic               ret_bank_q,  ret_bank_d;
    logic [IDX_W-1:0]   ret_idx_q,   ret_idx_d;
    logic [PIX_W-1:0]   pixel_q,     pixel_d;

    logic [COORD_W:0]   frog_dy_new;
    logic [COORD_W:0]   car_dy_new;
    logic               frog_hit_new;
    logic               car_hit_new;
    logic               fetching;
    logic               read_en;
    logic               wr_en;

    logic [COORD_W:0]   frog_off;
    logic [COORD_W:0]   car_off;
    logic               frog_cov;
    logic               car_cov;
    logic [PIX_W-1:0]   frog_pix;
    logic [PIX_W-1:0]   car_pix;

    // Line-hit decision on the freshly presented inputs.
    assign frog_dy_new  = coord_offset(i_next_row, i_frog_y);
    assign car_dy_new   = coord_offset(i_next_row, i_car_y);
    assign frog_hit_new = in_sprite(frog_dy_new);
    assign car_hit_new  = in_sprite(car_dy_new);

    // A new line start aborts the current fetch, so no read is issued in
    // that cycle; its return would be thrown away anyway.
    assign fetching = (state_q == FETCH_FROG) || (state_q == FETCH_CAR);
    assign read_en  = fetching && !i_line_start;

    assign o_read_en    = read_en;
    assign o_mem_select = read_en && (state_q == FETCH_CAR);
    assign o_read_addr  = !read_en ? '0 :
                          (state_q == FETCH_CAR) ? {car_dy_q, idx_q} : {frog_dy_q, idx_q};
    assign o_busy       = (state_q != IDLE);
    assign o_pixel      = pixel_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frog_dy_d  = frog_dy_q;
        car_dy_d   = car_dy_q;
        frog_hit_d = frog_hit_q;
        car_hit_d  = car_hit_q;
        frog_x_d   = frog_x_q;
        car_x_d    = car_x_q;

        if (i_line_start) begin
            frog_dy_d  = frog_dy_new[IDX_W-1:0];
            car_dy_d   = car_dy_new[IDX_W-1:0];
            frog_hit_d = frog_hit_new;
            car_hit_d  = car_hit_new;
            frog_x_d   = i_frog_x;
            car_x_d    = i_car_x;
            idx_d      = '0;
            if (frog_hit_new) begin
                state_d = FETCH_FROG;
            end else if (car_hit_new) begin
                state_d = FETCH_CAR;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                FETCH_FROG: begin
                    // idx wraps to 0, so FETCH_CAR starts with no bubble.
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = car_hit_q ? FETCH_CAR : DRAIN;
                    end
                end
                FETCH_CAR: begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Return pipe: tags each read so its data lands in the right buffer slot.
    always_comb begin
        ret_valid_d = read_en;
        ret_bank_d  = (state_q == FETCH_CAR);
        ret_idx_d   = idx_q;
    end

    assign wr_en = ret_valid_q && !i_line_start;

    sprite_line_buffer u_frog_line (
        .i_Clk   (i_Clk),
        .i_we    (wr_en && !ret_bank_q),
        .i_waddr (ret_idx_q),
        .i_wdata (i_read_data),
        .i_raddr (frog_off[IDX_W-1:0]),
        .o_rdata (frog_pix)
    );

    sprite_line_buffer u_car_line (
        .i_Clk   (i_Clk),
        .i_we    (wr_en && ret_bank_q),
        .i_waddr (ret_idx_q),
        .i_wdata (i_read_data),
        .i_raddr (car_off[IDX_W-1:0]),
        .o_rdata (car_pix)
    );

    // Compositor: frog over car over background.
    assign frog_off = coord_offset(i_col, frog_x_q);
    assign car_off  = coord_offset(i_col, car_x_q);
    assign frog_cov = frog_hit_q && in_sprite(frog_off);
    assign car_cov  = car_hit_q && in_sprite(car_off);

    always_comb begin
        pixel_d = '0;
        if (i_active) begin
            if (frog_cov && (frog_pix != TRANSPARENT)) begin
                pixel_d = frog_pix;
            end else if (car_cov && (car_pix != TRANSPARENT)) begin
                pixel_d = car_pix;
            end else begin
                pixel_d = BG_COLOUR;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frog_dy_q   <= '0;
            car_dy_q    <= '0;
            frog_hit_q  <= 1'b0;
            car_hit_q   <= 1'b0;
            frog_x_q    <= '0;
            car_x_q     <= '0;
            ret_valid_q <= 1'b0;
            ret_bank_q  <= 1'b0;
            ret_idx_q   <= '0;
            pixel_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frog_dy_q   <= frog_dy_d;
            car_dy_q    <= car_dy_d;
            frog_hit_q  <= frog_hit_d;
            car_hit_q   <= car_hit_d;
            frog_x_q    <= frog_x_d;
            car_x_q     <= car_x_d;
            ret_valid_q <= ret_valid_d;
            ret_bank_q  <= ret_bank_d;
            ret_idx_q   <= ret_idx_d;
            pixel_q     <= pixel_d;
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Self-checking bench for sprite_line_renderer with a 1-cycle-latency
// behavioural sprite memory (frog[a] = a[8:0], car[a] = ~a[8:0]).
module tb_sprite_line_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_start;
    logic [9:0] next_row, frog_x, frog_y, car_x, car_y, col;
    logic       active;
    logic       read_en;
    logic [9:0] read_addr;
    logic       mem_select;
    logic [8:0] read_data;
    logic [8:0] pixel;
    logic       busy;

    localparam int BG = 16;
    localparam int TR = 455;

    always #5 clk = ~clk;

    sprite_line_renderer dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_line_start (line_start),
        .i_next_row   (next_row),
        .i_frog_x     (frog_x),
        .i_frog_y     (frog_y),
        .i_car_x      (car_x),
        .i_car_y      (car_y),
        .i_active     (active),
        .i_col        (col),
        .o_read_en    (read_en),
        .o_read_addr  (read_addr),
        .o_mem_select (mem_select),
        .i_read_data  (read_data),
        .o_pixel      (pixel),
        .o_busy       (busy)
    );

    logic [8:0] frog_mem [1024];
    logic [8:0] car_mem  [1024];

    always @(posedge clk) begin
        if (read_en) begin
            read_data <= mem_select ? car_mem[read_addr] : frog_mem[read_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int rd_addr[$];
    int rd_sel[$];
    int busy_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_line(input int row, input int fx, input int fy, input int cx, input int cy);
        @(posedge clk); #1;
        next_row   = row[9:0];
        frog_x     = fx[9:0];
        frog_y     = fy[9:0];
        car_x      = cx[9:0];
        car_y      = cy[9:0];
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic monitor(input string tag);
        bit done = 1'b0;
        rd_addr.delete();
        rd_sel.delete();
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            busy_cnt++;
            if (read_en) begin
                rd_addr.push_back(int'(read_addr));
                rd_sel.push_back(int'(mem_select));
            end
        end
        if (!done) check({tag, "_busy_timeout"}, 1, 0);
    endtask

    task automatic check_reads(input string tag, input int nf, input int fb, input int nc, input int cb);
        int ea, es;
        check({tag, "_nreads"}, rd_addr.size(), nf + nc);
        for (int k = 0; k < rd_addr.size() && k < nf + nc; k++) begin
            ea = (k < nf) ? fb + k : cb + (k - nf);
            es = (k < nf) ? 0 : 1;
            check($sformatf("%s_addr%0d", tag, k), rd_addr[k], ea);
            check($sformatf("%s_sel%0d", tag, k), rd_sel[k], es);
        end
    endtask

    task automatic pix(input string name, input int c, input bit act, input int exp);
        @(posedge clk); #1;
        col    = c[9:0];
        active = act;
        @(posedge clk);
        @(negedge clk);
        check(name, pixel, exp);
        active = 1'b0;
    endtask

    typedef struct {
        int row, fx, fy, cx, cy;
        int busy, nf, fb, nc, cb;
        int col, pix;
    } line_vec_t;

    line_vec_t vecs[7];

    initial begin
        for (int a = 0; a < 1024; a++) begin
            frog_mem[a] = a[8:0];
            car_mem[a]  = ~a[8:0];
        end
        read_data  = '0;
        rst        = 1'b1;
        line_start = 1'b0;
        next_row   = '0;
        frog_x     = '0;
        frog_y     = '0;
        car_x      = '0;
        car_y      = '0;
        col        = '0;
        active     = 1'b0;

        //          row  fx   fy  cx   cy   busy nf fb   nc cb   col  pix
        vecs[0] = '{53,  100, 50, 0,   300, 33,  32, 96,  0, 0,   100, 96};
        vecs[1] = '{60,  100, 50, 110, 40,  65,  32, 320, 32, 640, 115, 335};
        vecs[2] = '{200, 100, 50, 0,   300, 0,   0,  0,   0, 0,   100, BG};
        vecs[3] = '{45,  100, 50, 110, 40,  33,  0,  0,   32, 160, 110, 351};
        vecs[4] = '{81,  100, 50, 0,   300, 33,  32, 992, 0, 0,   131, 511};
        vecs[5] = '{82,  100, 50, 0,   300, 0,   0,  0,   0, 0,   131, BG};
        vecs[6] = '{64,  100, 50, 100, 40,  65,  32, 448, 32, 768, 107, 248};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read_en", read_en, 0);
        check("rst_read_addr", read_addr, 0);
        check("rst_mem_select", mem_select, 0);
        check("rst_pixel", pixel, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            start_line(vecs[v].row, vecs[v].fx, vecs[v].fy, vecs[v].cx, vecs[v].cy);
            monitor($sformatf("v%0d", v));
            check($sformatf("v%0d_busy", v), busy_cnt, vecs[v].busy);
            check_reads($sformatf("v%0d", v), vecs[v].nf, vecs[v].fb, vecs[v].nc, vecs[v].cb);
            pix($sformatf("v%0d_pix", v), vecs[v].col, 1'b1, vecs[v].pix);
        end

        // Full frog-only line scan, edges of the sprite and inactive output.
        start_line(53, 100, 50, 0, 300);
        monitor("scan");
        pix("scan_col99", 99, 1'b1, BG);
        for (int k = 0; k < 32; k++) pix($sformatf("scan_col%0d", 100 + k), 100 + k, 1'b1, 96 + k);
        pix("scan_col132", 132, 1'b1, BG);
        pix("scan_inactive", 100, 1'b0, 0);

        // Transparent frog pixel with no car on the line.
        frog_mem[96] = TR[8:0];
        start_line(53, 100, 50, 0, 300);
        monitor("transp");
        pix("transp_col100", 100, 1'b1, BG);
        pix("transp_col101", 101, 1'b1, 97);
        frog_mem[96] = 9'd96;

        // Transparent frog pixel over the car: car[640+5] shows through.
        frog_mem[335] = TR[8:0];
        start_line(60, 100, 50, 110, 40);
        monitor("ovl");
        check("ovl_busy", busy_cnt, 65);
        pix("ovl_col115", 115, 1'b1, 378);
        pix("ovl_col116", 116, 1'b1, 336);
        frog_mem[335] = 9'd335;

        // Restart at fetch cycle 20 with a new row.
        start_line(53, 100, 50, 0, 300);
        repeat (19) @(posedge clk);
        start_line(51, 100, 50, 0, 300);
        monitor("rst20");
        check("rst20_busy", busy_cnt, 33);
        check_reads("rst20", 32, 32, 0, 0);
        pix("rst20_col100", 100, 1'b1, 32);
        pix("rst20_col115", 115, 1'b1, 47);
        pix("rst20_col131", 131, 1'b1, 63);

        // Reset in the middle of a fetch.
        start_line(53, 100, 50, 0, 300);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_read_en", read_en, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        pix("midrst_col100", 100, 1'b1, BG);

        // Right-edge clipping, no wrap to column 0.
        start_line(53, 620, 50, 0, 300);
        monitor("clip");
        for (int k = 0; k < 20; k++) pix($sformatf("clip_col%0d", 620 + k), 620 + k, 1'b1, 96 + k);
        pix("clip_col0", 0, 1'b1, BG);
        pix("clip_inactive", 620, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
